// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, redirect/kill handling and decode handshake.
// Optional stall-cycle counter output FetchStallCnt when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] Instr,
  output logic        InstrValidF,
  output logic        FetchBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchStallCnt
`endif
);

  typedef enum logic [1:0] {StIssue, StWait, StReady, StKill} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] redirect_pc;
  logic        unused_tgt_lsb;

  assign redirect_pc    = {PCTargetE[31:2], 2'b00};
  assign unused_tgt_lsb = ^PCTargetE[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIssue;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // A redirect beats a stall everywhere; responses arriving in StIssue/StReady are ignored.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIssue: begin
        if (PCSrcE) begin
          pc_d    = redirect_pc;
          state_d = StKill;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (PCSrcE) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? StIssue : StKill;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StReady;
        end
      end
      StReady: begin
        if (PCSrcE) begin
          pc_d    = redirect_pc;
          state_d = StIssue;
        end else if (!StallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = StIssue;
        end
      end
      StKill: begin
        // A response landing together with a new redirect still retires the stale request.
        if (PCSrcE) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? StIssue : StKill;
        end else if (imem_rvalid) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  // Outputs are forced to their reset view combinationally while reset is held.
  always_comb begin
    PCF         = reset ? RESET_PC : pc_q;
    PCPlus4F    = PCF + 32'd4;
    imem_addr   = PCF;
    imem_req    = !reset && (state_q == StIssue);
    InstrValidF = !reset && (state_q == StReady);
    Instr       = InstrValidF ? instr_q : 32'h0;
    FetchBusy   = reset || (state_q != StReady);
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q != StReady) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign FetchStallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, StallF, PCSrcE, imem_rvalid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, InstrValidF, FetchBusy;
  logic [31:0] imem_addr, PCF, PCPlus4F, Instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchStallCnt;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .Instr      (Instr),
    .InstrValidF(InstrValidF),
    .FetchBusy  (FetchBusy)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchStallCnt(FetchStallCnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: a pending issue, an outstanding request (possibly doomed), and a held word.
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_word    = 32'h0;
  logic [31:0] m_cnt     = 32'h0;
  bit          m_issue   = 1'b0;
  bit          m_outst   = 1'b0;
  bit          m_discard = 1'b0;
  bit          m_have    = 1'b0;

  // Memory: single response slot with a latency chosen at request time.
  bit          mem_pending = 1'b0;
  int          mem_wait    = 0;
  logic [31:0] mem_word    = 32'h0;
  int          mem_lat     = 1;
  bit          dir_data_en = 1'b1;
  logic [31:0] dir_data    = 32'h0;
  bit          inject      = 1'b0;
  logic [31:0] inject_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then compare every output against the model mid-cycle.
  task automatic drive(input bit r, input bit st, input bit src, input logic [31:0] tgt);
    logic        e_valid;
    logic [31:0] e_pc;
    reset     = r;
    StallF    = st;
    PCSrcE    = src;
    PCTargetE = tgt;
    if (mem_pending && mem_wait == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word;
    end else if (inject) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inject_data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    inject = 1'b0;
    @(negedge clk);
    e_valid = !r && m_have;
    e_pc    = r ? RESET_PC : m_pc;
    chk("imem_req", 32'(imem_req), 32'(!r && m_issue));
    chk("imem_addr", imem_addr, e_pc);
    chk("PCF", PCF, e_pc);
    chk("PCPlus4F", PCPlus4F, e_pc + 32'd4);
    chk("InstrValidF", 32'(InstrValidF), 32'(e_valid));
    chk("Instr", Instr, e_valid ? m_word : 32'h0);
    chk("FetchBusy", 32'(FetchBusy), 32'(r || !m_have));
`ifdef FETCH_PERF_CNT_EN
    if (!r) chk("FetchStallCnt", FetchStallCnt, m_cnt);
`endif
  endtask

  // Advance model and memory across the rising edge using the inputs just applied.
  task automatic step();
    bit req_now, got, live;
    @(posedge clk);
    req_now = !reset && m_issue;
    if (reset) mem_pending = 1'b0;
    else if (mem_pending) begin
      if (mem_wait == 0) mem_pending = 1'b0;
      else mem_wait--;
    end
    if (req_now) begin
      mem_pending = 1'b1;
      mem_wait    = (mem_lat > 0 ? mem_lat : int'($urandom_range(1, 4))) - 1;
      mem_word    = dir_data_en ? dir_data : $urandom;
    end
    if (reset) m_cnt = 32'h0;
    else if (!m_have && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (reset) begin
      m_pc = RESET_PC; m_issue = 1'b1; m_outst = 1'b0; m_discard = 1'b0; m_have = 1'b0;
      m_word = 32'h0;
    end else begin
      got  = imem_rvalid && m_outst;
      live = got && !m_discard;
      if (got) begin
        m_outst   = 1'b0;
        m_discard = 1'b0;
      end
      if (m_issue) begin
        m_outst = 1'b1;
        m_issue = 1'b0;
      end
      if (PCSrcE) begin
        m_pc   = PCTargetE & ~32'd3;
        m_have = 1'b0;
        if (m_outst) m_discard = 1'b1;
        else m_issue = 1'b1;
      end else if (live) begin
        m_have = 1'b1;
        m_word = imem_rdata;
      end else if (got) begin
        m_issue = 1'b1;
      end else if (m_have && !StallF) begin
        m_have  = 1'b0;
        m_pc    = m_pc + 32'd4;
        m_issue = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    // Reset release and first fetch with a 1-cycle memory.
    mem_lat  = 1;
    dir_data = 32'h0050_0093;
    drive(1, 0, 0, 0);
    step();
    drive(1, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(InstrValidF), 32'd0);
    chk("rst_pcf", PCF, 32'h0);
    step();
    drive(0, 1, 0, 0);
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    step();
    drive(0, 1, 0, 0);
    chk("c2_req", 32'(imem_req), 32'd0);
    chk("c2_busy", 32'(FetchBusy), 32'd1);
    step();
    drive(0, 1, 0, 0);
    chk("c3_valid", 32'(InstrValidF), 32'd1);
    chk("c3_instr", Instr, 32'h0050_0093);
    chk("c3_pcf", PCF, 32'h0);
    chk("c3_pc4", PCPlus4F, 32'h4);
    step();

    // Held under stall for five cycles, then consumed.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0);
      chk("stall_valid", 32'(InstrValidF), 32'd1);
      chk("stall_instr", Instr, 32'h0050_0093);
      chk("stall_pcf", PCF, 32'h0);
      chk("stall_req", 32'(imem_req), 32'd0);
      step();
    end
    drive(0, 0, 0, 0);
    step();
    mem_lat  = 3;
    dir_data = 32'hDEAD_BEEF;
    drive(0, 1, 0, 0);
    chk("next_req", 32'(imem_req), 32'd1);
    chk("next_addr", imem_addr, 32'h4);
    step();

    // Redirect while waiting: the late response must never surface.
    drive(0, 0, 1, 32'h0000_0103);
    step();
    drive(0, 0, 0, 0);
    chk("kill_pcf", PCF, 32'h100);
    chk("kill_valid", 32'(InstrValidF), 32'd0);
    chk("kill_req", 32'(imem_req), 32'd0);
    step();
    drive(0, 0, 0, 0);
    chk("kill_drop_valid", 32'(InstrValidF), 32'd0);
    chk("kill_drop_instr", Instr, 32'h0);
    step();
    mem_lat  = 1;
    dir_data = 32'h1111_1111;
    drive(0, 0, 0, 0);
    chk("kill_next_req", 32'(imem_req), 32'd1);
    chk("kill_next_addr", imem_addr, 32'h100);
    step();

    // Redirect wins over stall in READY.
    drive(0, 1, 0, 0);
    step();
    drive(0, 1, 1, 32'h0000_0200);
    chk("rs_instr", Instr, 32'h1111_1111);
    step();
    drive(0, 0, 0, 0);
    chk("rs_req", 32'(imem_req), 32'd1);
    chk("rs_addr", imem_addr, 32'h200);
    chk("rs_valid", 32'(InstrValidF), 32'd0);
    step();

    // PC wrap at the top of the address space.
    drive(0, 1, 0, 0);
    step();
    drive(0, 1, 1, 32'hFFFF_FFFF);
    step();
    drive(0, 1, 0, 0);
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    step();
    drive(0, 1, 0, 0);
    step();
    drive(0, 0, 0, 0);
    chk("wrap_valid", 32'(InstrValidF), 32'd1);
    step();
    mem_lat = 3;
    drive(0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    step();

    // Reset while waiting, then a stray response in the first issue cycle.
    drive(1, 1, 0, 0);
    step();
    mem_lat     = 1;
    dir_data    = 32'h2222_2222;
    inject      = 1'b1;
    inject_data = 32'hBAD0_BAD0;
    drive(0, 1, 0, 0);
    chk("late_req", 32'(imem_req), 32'd1);
    step();
    drive(0, 1, 0, 0);
    step();
    drive(0, 1, 0, 0);
    chk("late_valid", 32'(InstrValidF), 32'd1);
    chk("late_instr", Instr, 32'h2222_2222);
    step();

    // Random traffic with random latency, stalls, redirects, resets and stray responses.
    mem_lat     = 0;
    dir_data_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      inject      = !mem_pending && ($urandom_range(0, 7) == 0);
      inject_data = $urandom;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 11) == 0), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] SHALL be 0.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 StallF  in  1  hazard-unit stall; 1 = hold the presented instruction.
REQ-005 PCSrcE  in  1  redirect request from execute stage.
REQ-006 PCTargetE  in  32  redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  out  1  instruction-memory request strobe, one cycle per request.
REQ-008 imem_addr  out  32  request address; SHALL equal PCF.
REQ-009 imem_rvalid  in  1  response strobe, exactly one per request, at least 1 cycle after imem_req.
REQ-010 imem_rdata  in  32  response word; valid only while imem_rvalid=1.
REQ-011 PCF  out  32  PC of the fetched or pending instruction.
REQ-012 PCPlus4F  out  32  PCF+4, modulo 2^32.
REQ-013 Instr  out  32  fetched instruction; 32'h0 when InstrValidF=0.
REQ-014 InstrValidF  out  1  Instr/PCF pair valid for decode capture.
REQ-015 FetchBusy  out  1  1 when state != READY; the hazard unit SHALL stall or flush decode.

Function
REQ-016 The FSM SHALL have states ISSUE, WAIT, READY and KILL.
REQ-017 imem_req SHALL be combinational, 1 exactly when state=ISSUE, with imem_addr=PCF.
REQ-018 ISSUE: go to WAIT unconditionally unless REQ-023 applies.
REQ-019 WAIT, imem_rvalid=1: capture imem_rdata into the instruction register and go to READY.
REQ-020 WAIT, imem_rvalid=0: stay in WAIT; no timeout.
REQ-021 READY: InstrValidF=1; Instr and PCF SHALL stay stable while StallF=1.
REQ-022 READY, StallF=0, PCSrcE=0: PCF <= PCF+4; go to ISSUE. Decode consumes the word on this same edge.
REQ-023 PCSrcE=1 SHALL take priority over StallF in every state, setting PCF <= {PCTargetE[31:2],2'b00}.
REQ-024 Redirect next state: ISSUE or WAIT without rvalid -> KILL; WAIT with rvalid the same cycle -> ISSUE, data discarded; READY -> ISSUE, held word dropped; KILL -> KILL.
REQ-025 KILL: InstrValidF=0; the next imem_rvalid SHALL be discarded and the state go to ISSUE.
REQ-026 imem_rvalid SHALL be ignored in ISSUE and READY; it is a protocol error and has no effect.
REQ-027 Minimum throughput SHALL be one instruction per 3 cycles with 1-cycle memory latency.
REQ-028 At most one request SHALL be outstanding at any time.

Reset
REQ-029 While reset=1: PCF=RESET_PC, state=ISSUE, instruction register=0, InstrValidF=0, imem_req=0 (overrides REQ-017).
REQ-030 First request SHALL go out in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-031 Reset in WAIT or KILL SHALL abandon the outstanding request; a late imem_rvalid in the first ISSUE cycle after reset SHALL be ignored (per REQ-026).

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: the block SHALL add output FetchStallCnt[31:0].
REQ-033 FetchStallCnt SHALL count cycles with FetchBusy=1 and reset=0, reset to 0, and saturate at 32'hFFFF_FFFF.
REQ-034 FETCH_PERF_CNT_EN undefined: the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Reset release, RESET_PC=0, 1-cycle memory returning 32'h00500093: imem_req at cycle 1 with addr 0; InstrValidF=1 at cycle 3 with Instr=32'h00500093, PCF=0, PCPlus4F=4.
REQ-036 READY with StallF=1 for 5 cycles: Instr, PCF and InstrValidF unchanged and imem_req=0 throughout; after release, next request addr=4.
REQ-037 PCSrcE=1 with PCTargetE=32'h0000_0103 while WAIT and no rvalid: PCF=32'h100 and state KILL; the next rvalid (data 32'hDEADBEEF) is never presented; the following request uses addr 32'h100.
REQ-038 PCSrcE=1 and StallF=1 in READY: the held word is dropped, then request addr=PCTargetE; the redirect wins over the stall.
REQ-039 PCF=32'hFFFF_FFFC: PCPlus4F=0; after consume, next request addr=0.
REQ-040 With FETCH_PERF_CNT_EN: a 4-cycle memory latency for one fetch adds 5 to FetchStallCnt (1 ISSUE + 4 WAIT); FetchStallCnt=0 after reset.
